// File: rtl/vector_store_serializer_if.sv
// vector_store_serializer_if: upstream vector handshake plus downstream memory write port.
interface vector_store_serializer_if #(parameter int N = 24, parameter int M = 6, parameter int AW = 16);
    logic          in_valid;
    logic          in_ready;
    logic [M*N-1:0] result;
    logic [AW-1:0] base_addr;
    logic [M-1:0]  lane_mask;
    logic          mem_stall;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          busy;
    logic          done;
    modport slave (
        input  in_valid, result, base_addr, lane_mask, mem_stall,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done
    );
    modport master (
        output in_valid, result, base_addr, lane_mask, mem_stall,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/vector_store_serializer.sv
// vector_store_serializer: captures one lane vector and writes its enabled lanes to memory, one lane per cycle.
module vector_store_serializer #(parameter int N = 24, parameter int M = 6, parameter int AW = 16) (
    input logic clk,
    input logic rst,
    vector_store_serializer_if.slave bus
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_WRITE = 2'd1, S_DONE = 2'd2;
    logic [1:0]     r_state;
    logic [IW-1:0]  r_idx;
    logic [M*N-1:0] r_vec;
    logic [AW-1:0]  r_base;
    logic [M-1:0]   r_mask;
    logic           w_write;
    logic           w_last;
    assign w_write = r_state == S_WRITE;
    assign w_last  = r_idx == IW'(M - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_vec   <= '0;
            r_base  <= '0;
            r_mask  <= '0;
        end else if (r_state == S_IDLE && bus.in_valid) begin
            r_state <= S_WRITE;
            r_idx   <= '0;
            r_vec   <= bus.result;
            r_base  <= bus.base_addr;
            r_mask  <= bus.lane_mask;
        end else if (w_write && !bus.mem_stall) begin
            r_state <= w_last ? S_DONE : S_WRITE;
            r_idx   <= w_last ? r_idx : r_idx + 1'b1;
        end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
        end
    end
    // masked lanes still occupy a cycle, so latency never depends on the mask
    assign bus.in_ready  = r_state == S_IDLE && !rst;
    assign bus.mem_we    = w_write && r_mask[r_idx];
    assign bus.mem_addr  = w_write ? r_base + AW'(r_idx) : '0;
    assign bus.mem_wdata = w_write ? r_vec[r_idx*N +: N] : '0;
    assign bus.busy      = r_state != S_IDLE;
    assign bus.done      = r_state == S_DONE;
endmodule

// File: tb/tb_vector_store_serializer.sv
// tb_vector_store_serializer: directed vector table plus reset and back-to-back sequences.
module tb_vector_store_serializer;
    typedef struct {
        logic [143:0]      result;
        logic [15:0]       base;
        logic [5:0]        mask;
        int                stall_lane;
        int                stall_len;
        logic [5:0]        exp_we;
        logic [5:0][15:0]  exp_addr;
        logic [5:0][23:0]  exp_data;
        int                exp_lat;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_fail = 0;
    vec_t tv[6];
    vector_store_serializer_if #(.N(24), .M(6), .AW(16)) bus();
    vector_store_serializer #(.N(24), .M(6), .AW(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic run_vec(input vec_t v);
        int lane, st, wr, cyc, w;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before", bus.in_ready, 1);
        bus.in_valid = 1; bus.result = v.result; bus.base_addr = v.base; bus.lane_mask = v.mask;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 0; bus.result = ~v.result; bus.base_addr = ~v.base; bus.lane_mask = ~v.mask;
        lane = 0; st = v.stall_len; wr = 0; cyc = 1;
        while (lane < 6 && cyc < 40) begin
            bus.mem_stall = (lane == v.stall_lane && st > 0);
            chk("busy", bus.busy, 1);
            chk("ready_busy", bus.in_ready, 0);
            chk("we", bus.mem_we, v.exp_we[lane]);
            chk("addr", bus.mem_addr, v.exp_addr[lane]);
            chk("wdata", bus.mem_wdata, v.exp_data[lane]);
            if (bus.mem_we && !bus.mem_stall) wr++;
            if (bus.mem_stall) st--; else lane++;
            @(negedge clk);
            cyc++;
        end
        bus.mem_stall = 1;
        chk("done", bus.done, 1);
        chk("done_busy", bus.busy, 1);
        chk("done_we", bus.mem_we, 0);
        chk("done_addr", bus.mem_addr, 0);
        chk("latency", cyc, v.exp_lat);
        chk("writes", wr, $countones(v.exp_we));
        @(negedge clk);
        bus.mem_stall = 0;
        chk("done_pulse", bus.done, 0);
        chk("ready_after", bus.in_ready, 1);
        chk("idle_wdata", bus.mem_wdata, 0);
    endtask
    initial begin
        tv[0] = '{{24'h000006, 24'h000005, 24'h000004, 24'h000003, 24'h000002, 24'h000001}, 16'h0100, 6'b111111, -1, 0, 6'b111111,
                  {16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100},
                  {24'h000006, 24'h000005, 24'h000004, 24'h000003, 24'h000002, 24'h000001}, 7};
        tv[1] = '{{24'hFFFFFF, 24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA}, 16'h0020, 6'b100101, -1, 0, 6'b100101,
                  {16'h0025, 16'h0024, 16'h0023, 16'h0022, 16'h0021, 16'h0020},
                  {24'hFFFFFF, 24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA}, 7};
        tv[2] = '{{24'hFFFFFF, 24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA}, 16'h0020, 6'b000000, -1, 0, 6'b000000,
                  {16'h0025, 16'h0024, 16'h0023, 16'h0022, 16'h0021, 16'h0020},
                  {24'hFFFFFF, 24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA}, 7};
        tv[3] = '{{24'h666666, 24'h555555, 24'h444444, 24'h333333, 24'h222222, 24'h111111}, 16'h0300, 6'b111111, 2, 3, 6'b111111,
                  {16'h0305, 16'h0304, 16'h0303, 16'h0302, 16'h0301, 16'h0300},
                  {24'h666666, 24'h555555, 24'h444444, 24'h333333, 24'h222222, 24'h111111}, 10};
        tv[4] = '{{24'h6789AB, 24'h56789A, 24'h456789, 24'h345678, 24'h234567, 24'h123456}, 16'hFFFD, 6'b111111, -1, 0, 6'b111111,
                  {16'h0002, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFD},
                  {24'h6789AB, 24'h56789A, 24'h456789, 24'h345678, 24'h234567, 24'h123456}, 7};
        tv[5] = '{{24'h600000, 24'h500000, 24'h400000, 24'h300000, 24'h200000, 24'h100000}, 16'h0040, 6'b011011, 2, 2, 6'b011011,
                  {16'h0045, 16'h0044, 16'h0043, 16'h0042, 16'h0041, 16'h0040},
                  {24'h600000, 24'h500000, 24'h400000, 24'h300000, 24'h200000, 24'h100000}, 9};
        rst = 1; bus.in_valid = 0; bus.result = '0; bus.base_addr = '0; bus.lane_mask = '0; bus.mem_stall = 0;
        #1;
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("idle_ready", bus.in_ready, 1);
        chk("idle_addr", bus.mem_addr, 0);
        chk("idle_wdata", bus.mem_wdata, 0);
        for (int i = 0; i < 6; i++) run_vec(tv[i]);
        // asynchronous reset while lane 3 is on the bus
        @(negedge clk);
        bus.in_valid = 1; bus.result = tv[0].result; bus.base_addr = tv[0].base; bus.lane_mask = tv[0].mask;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("pre_rst_addr", bus.mem_addr, 16'h0103);
        chk("pre_rst_we", bus.mem_we, 1);
        #2 rst = 1;
        #1;
        chk("arst_we", bus.mem_we, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_ready", bus.in_ready, 0);
        chk("arst_addr", bus.mem_addr, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_hold_we", bus.mem_we, 0);
        end
        rst = 0;
        #1;
        chk("post_rst_ready", bus.in_ready, 1);
        chk("post_rst_busy", bus.busy, 0);
        run_vec(tv[4]);
        // in_valid held high; upstream switches to the next vector right after acceptance
        @(negedge clk);
        bus.in_valid = 1; bus.result = tv[0].result; bus.base_addr = tv[0].base; bus.lane_mask = tv[0].mask;
        @(posedge clk);
        @(negedge clk);
        bus.result = tv[1].result; bus.base_addr = tv[1].base; bus.lane_mask = tv[1].mask;
        for (int k = 0; k < 6; k++) begin
            chk("b2b_ready_busy", bus.in_ready, 0);
            chk("b2b_addr", bus.mem_addr, tv[0].exp_addr[k]);
            chk("b2b_wdata", bus.mem_wdata, tv[0].exp_data[k]);
            chk("b2b_we", bus.mem_we, 1);
            @(negedge clk);
        end
        chk("b2b_done", bus.done, 1);
        chk("b2b_done_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("b2b_ready", bus.in_ready, 1);
        chk("b2b_idle_busy", bus.busy, 0);
        @(negedge clk);
        bus.in_valid = 0;
        chk("b2b2_addr", bus.mem_addr, 16'h0020);
        chk("b2b2_wdata", bus.mem_wdata, 24'hAAAAAA);
        chk("b2b2_we", bus.mem_we, 1);
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("b2b2_done", bus.done, 1);
        @(negedge clk);
        chk("b2b2_ready", bus.in_ready, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
